// File: rtl/game_ctrl.sv
// Game controller: start synchroniser, IDLE/RUN/HIT/OVER state machine,
// collision latch, and binary + cascaded-BCD current and high score counters.
module game_ctrl #(
    parameter int SCORE_MAX  = 9999,
    parameter int HIT_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        goose,
    input  logic        bean,
    input  logic        frame_end,
    input  logic        score_tick,
    input  logic        start,
    output logic        hit,
    output logic        running,
    output logic [13:0] score,
    output logic [13:0] score_hi,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_bcd,
    output logic        new_hi
);

    localparam int              CNT_W      = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
    localparam logic [13:0]     MAX_BIN    = 14'(SCORE_MAX);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(HIT_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic             start_s1;
    logic             start_s2;
    logic             start_prev;
    logic             start_armed;
    logic [1:0]       sync_fill;
    logic             start_edge;
    logic             overlap_now;
    logic             overlap_latch;
    logic             collide;
    logic [CNT_W-1:0] frame_cnt;
    logic             tick_ok;
    logic [13:0]      score_now;
    logic [15:0]      bcd_now;
    logic             game_start;

    // One decade step across four digits; a 9 rolls to 0 and carries upward.
    function automatic logic [15:0] bcd_increment(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // The arm flag blocks a start level that was already high at reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_s1    <= 1'b0;
            start_s2    <= 1'b0;
            start_prev  <= 1'b0;
            start_armed <= 1'b0;
            sync_fill   <= 2'b00;
        end else begin
            start_s1   <= start;
            start_s2   <= start_s1;
            start_prev <= start_s2;
            sync_fill  <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && !start_s2) begin
                start_armed <= 1'b1;
            end
        end
    end

    assign start_edge  = start_armed & start_s2 & ~start_prev;
    assign overlap_now = goose & bean;
    assign collide     = (state == RUN) & frame_end & (overlap_latch | overlap_now);
    assign game_start  = start_edge & ((state == IDLE) | (state == OVER));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overlap_latch <= 1'b0;
        end else if ((state == RUN) && !frame_end) begin
            overlap_latch <= overlap_latch | overlap_now;
        end else begin
            overlap_latch <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (state != HIT) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_edge) state_next = RUN;
            RUN:  if (collide) state_next = HIT;
            HIT:  if (frame_end && (frame_cnt == LAST_FRAME)) state_next = OVER;
            OVER: if (start_edge) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // The tick landing on the collision cycle is included in the high-score compare.
    assign tick_ok   = (state == RUN) & score_tick & (score < MAX_BIN);
    assign score_now = tick_ok ? score + 14'd1 : score;
    assign bcd_now   = tick_ok ? bcd_increment(score_bcd) : score_bcd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score     <= '0;
            score_bcd <= '0;
            score_hi  <= '0;
            hi_bcd    <= '0;
            new_hi    <= 1'b0;
        end else if (game_start) begin
            score     <= '0;
            score_bcd <= '0;
            new_hi    <= 1'b0;
        end else if (state == RUN) begin
            score     <= score_now;
            score_bcd <= bcd_now;
            if (collide && (score_now > score_hi)) begin
                score_hi <= score_now;
                hi_bcd   <= bcd_now;
                new_hi   <= 1'b1;
            end
        end
    end

    assign hit     = (state == HIT) | (state == OVER);
    assign running = (state == RUN);

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl with HIT_FRAMES=3: expected output vectors
// are queued as stimulus is driven and compared when the DUT settles.
module tb_game_ctrl;

    logic        clk;
    logic        reset;
    logic        goose;
    logic        bean;
    logic        frame_end;
    logic        score_tick;
    logic        start;
    logic        hit;
    logic        running;
    logic [13:0] score;
    logic [13:0] score_hi;
    logic [15:0] score_bcd;
    logic [15:0] hi_bcd;
    logic        new_hi;

    typedef struct {
        string       name;
        logic [62:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    game_ctrl #(.SCORE_MAX(9999), .HIT_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .goose(goose), .bean(bean),
        .frame_end(frame_end), .score_tick(score_tick), .start(start),
        .hit(hit), .running(running), .score(score), .score_hi(score_hi),
        .score_bcd(score_bcd), .hi_bcd(hi_bcd), .new_hi(new_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Packed order: hit, running, new_hi, score, score_hi, score_bcd, hi_bcd.
    function automatic logic [62:0] mk(input bit h, input bit r, input bit nh, input int s, input int hs);
        return {h, r, nh, 14'(s), 14'(hs), to_bcd(s), to_bcd(hs)};
    endfunction

    function automatic logic [62:0] observed();
        return {hit, running, new_hi, score, score_hi, score_bcd, hi_bcd};
    endfunction

    task automatic expect_vec(input string name, input logic [62:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_start();
        start = 1'b1;
        tick(3);
        start = 1'b0;
        tick(3);
    endtask

    task automatic run_ticks(input int n);
        score_tick = 1'b1;
        tick(n);
        score_tick = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        tick(1);
    endtask

    task automatic collide_now(input bit with_tick);
        score_tick = with_tick;
        goose      = 1'b1;
        bean       = 1'b1;
        frame_end  = 1'b1;
        tick(1);
        score_tick = 1'b0;
        goose      = 1'b0;
        bean       = 1'b0;
        frame_end  = 1'b0;
    endtask

    task automatic end_game(input bit with_tick);
        collide_now(with_tick);
        repeat (3) frame_pulse();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0;
        expect_vec("reset_state", mk(0, 0, 0, 0, 0));
        #3;
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_run_count();
        exp_t e;
        press_start();
        expect_vec("start_run", mk(0, 1, 0, 0, 0));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        run_ticks(1234);
        expect_vec("count_1234", mk(0, 1, 0, 1234, 0));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
    endtask

    task automatic test_collision();
        exp_t e;
        goose = 1'b1;
        bean  = 1'b1;
        tick(1);
        goose = 1'b0;
        bean  = 1'b0;
        tick(5);
        expect_vec("overlap_no_frame", mk(0, 1, 0, 1234, 0));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        expect_vec("hit_next_cycle", mk(1, 0, 1, 1234, 1234));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        score_tick = 1'b1;
        frame_pulse();
        frame_pulse();
        score_tick = 1'b0;
        expect_vec("hit_score_frozen", mk(1, 0, 1, 1234, 1234));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        press_start();
        expect_vec("start_ignored_in_hit", mk(1, 0, 1, 1234, 1234));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        frame_pulse();
        expect_vec("over_after_3_frames", mk(1, 0, 1, 1234, 1234));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        press_start();
        expect_vec("restart_from_over", mk(0, 1, 0, 0, 1234));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
    endtask

    task automatic test_high_score();
        exp_t e;
        do_reset();
        press_start();
        run_ticks(50);
        end_game(1'b0);
        expect_vec("game1_hi50", mk(1, 0, 1, 50, 50));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        press_start();
        expect_vec("game2_start", mk(0, 1, 0, 0, 50));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        run_ticks(30);
        end_game(1'b0);
        expect_vec("game2_keeps_hi", mk(1, 0, 0, 30, 50));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        press_start();
        run_ticks(50);
        end_game(1'b1);
        expect_vec("game3_tick_on_collide", mk(1, 0, 1, 51, 51));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
    endtask

    task automatic test_frame_latch();
        exp_t e;
        press_start();
        frame_pulse();
        frame_pulse();
        expect_vec("no_overlap_frames", mk(0, 1, 0, 0, 51));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        goose = 1'b1;
        tick(1);
        goose = 1'b0;
        bean  = 1'b1;
        tick(1);
        bean  = 1'b0;
        frame_pulse();
        expect_vec("sprites_apart", mk(0, 1, 0, 0, 51));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        goose = 1'b1;
        bean  = 1'b1;
        tick(1);
        goose = 1'b0;
        bean  = 1'b0;
        tick(3);
        expect_vec("latched_waiting", mk(0, 1, 0, 0, 51));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        frame_pulse();
        expect_vec("latched_hit", mk(1, 0, 0, 0, 51));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        do_reset();
        press_start();
        run_ticks(999);
        expect_vec("bcd_0999", mk(0, 1, 0, 999, 0));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        run_ticks(1);
        expect_vec("bcd_carry_1000", mk(0, 1, 0, 1000, 0));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        run_ticks(9050);
        expect_vec("saturate_9999", mk(0, 1, 0, 9999, 0));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
    endtask

    task automatic test_reset_in_hit();
        exp_t e;
        do_reset();
        press_start();
        run_ticks(77);
        collide_now(1'b0);
        expect_vec("hit_hi77", mk(1, 0, 1, 77, 77));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        #2;
        reset = 1'b0;
        expect_vec("async_reset_in_hit", mk(0, 0, 0, 0, 0));
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        start = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(10);
        expect_vec("held_start_stays_idle", mk(0, 0, 0, 0, 0));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
        start = 1'b0;
        tick(4);
        press_start();
        expect_vec("fresh_start_edge", mk(0, 1, 0, 0, 0));
        e = exp_q.pop_front();
        vectors++;
        if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", e.name, observed(), e.v);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        goose       = 1'b0;
        bean        = 1'b0;
        frame_end   = 1'b0;
        score_tick  = 1'b0;
        start       = 1'b0;
        test_reset();
        test_run_count();
        test_collision();
        test_high_score();
        test_frame_latch();
        test_saturation();
        test_reset_in_hit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter SCORE_MAX, default 9999, saturation value of the score counter (maximum 9999).
REQ-002 SHALL have parameter HIT_FRAMES, default 60, number of frame_end pulses the HIT state lasts (minimum 1).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port goose  input  1  current pixel belongs to the goose sprite.
REQ-006 SHALL have port bean  input  1  current pixel belongs to the bean sprite.
REQ-007 SHALL have port frame_end  input  1  one-cycle pulse once per video frame, after the last visible pixel.
REQ-008 SHALL have port score_tick  input  1  one-cycle score increment enable.
REQ-009 SHALL have port start  input  1  asynchronous start button, level, active-high.
REQ-010 SHALL have port hit  output  1  collision flag, high in HIT and OVER states.
REQ-011 SHALL have port running  output  1  high only in RUN state.
REQ-012 SHALL have port score  output  14  binary current score.
REQ-013 SHALL have port score_hi  output  14  binary high score.
REQ-014 SHALL have port score_bcd  output  16  current score as 4 BCD digits, thousands in [15:12].
REQ-015 SHALL have port hi_bcd  output  16  high score as 4 BCD digits, thousands in [15:12].
REQ-016 SHALL have port new_hi  output  1  high while the last finished game set a new high score.

Function
REQ-017 SHALL synchronise start through two flip-flops and act only on its rising edge (sync level 0->1); this gives 3 cycles latency from pin to edge detect.
REQ-018 SHALL implement states IDLE, RUN, HIT, OVER.
REQ-019 IDLE->RUN on start edge; score and score_bcd cleared on that transition; new_hi cleared.
REQ-020 RUN: score_tick increments score and score_bcd by 1 in the same cycle, saturating at SCORE_MAX (both frozen at 9999/0x9999).
REQ-021 RUN: any cycle with goose&bean sets an overlap latch; the latch is evaluated only on frame_end.
REQ-022 RUN: frame_end with latch set (or goose&bean in that same cycle) -> HIT next cycle; the latch clears on every frame_end.
REQ-023 On RUN->HIT: if score > score_hi, score_hi<=score, hi_bcd<=score_bcd and new_hi<=1, all in the same edge.
REQ-024 HIT: score frozen; score_tick ignored; a frame counter counts frame_end pulses; the HIT_FRAMES-th pulse -> OVER.
REQ-025 OVER: score and score_hi held; start edge -> RUN with score cleared and new_hi cleared.
REQ-026 start edges in RUN or HIT SHALL be ignored.
REQ-027 Same-cycle score_tick and collision in RUN: the tick counts, and that score is compared for high score.
REQ-028 BCD digits SHALL be kept as cascaded decade counters (digit 9 rolls to 0 with carry), never by combinational conversion; score_bcd SHALL always equal the decimal form of score.
REQ-029 Outputs SHALL be registered; hit and running reflect the state register, with no combinational path from inputs.

Reset
REQ-030 reset low SHALL immediately set state IDLE, hit=0, running=0, score=0, score_hi=0, score_bcd=0, hi_bcd=0, new_hi=0, and clear the overlap latch, frame counter and start synchroniser.
REQ-031 Reset asserted mid-game (any state) SHALL discard the high score; it persists only across games, not across reset.
REQ-032 After reset release, IDLE SHALL require a fresh start edge; a start held high through release SHALL NOT start a game.

Verification
REQ-033 Reset, start pulse, 1234 score_tick -> running=1, score=1234, score_bcd=0x1234, hit=0.
REQ-034 In RUN, goose&bean for 1 cycle mid-frame, then frame_end -> hit=1 next cycle; with HIT_FRAMES=3, hit stays 1 and state reaches OVER after the 3rd frame_end; score frozen.
REQ-035 Game 1 ends at 50, game 2 ends at 30 -> score_hi=50, hi_bcd=0x0050, new_hi=0; game 3 ends at 51 -> score_hi=51, new_hi=1.
REQ-036 10050 ticks in RUN -> score=9999, score_bcd=0x9999; 0x0999->0x1000 carry checked on the way.
REQ-037 Overlap and frame_end in the same cycle -> HIT; overlap in frame N, with latch cleared, no overlap in frame N+1 -> HIT on frame N's frame_end only.
REQ-038 reset low during HIT with score_hi=77 -> all outputs 0 asynchronously; start held high across release -> stays IDLE.
